// File: rtl/branch_sequencer.sv
// Control-step sequencer for the Mini SRC conditional-branch path: fetch (T0-T2),
// branch execute (T3-T6), memory wait in T1W, and a saturating taken-branch counter.
module branch_sequencer #(
    parameter logic [4:0] BR_OPCODE = 5'b10010,
    parameter int         CNT_W     = 16
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             Start,
    input  logic             MemReady,
    input  logic [31:0]      IR,
    input  logic             CON,
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             Zin,
    output logic             Zlowout,
    output logic             PCin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Gra,
    output logic             Rout,
    output logic             CONin,
    output logic             Yin,
    output logic             Cout,
    output logic             ADD,
    output logic             Busy,
    output logic             Done,
    output logic             NotBranch,
    output logic [CNT_W-1:0] TakenCount
);

    typedef enum logic [3:0] {
        IDLE, T0, T1, T1W, T2, T3, T4, T5, T6
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_br;
    logic             unused_ir;

    assign is_br     = (IR[31:27] == BR_OPCODE);
    assign unused_ir = ^IR[26:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (Start) state_d = T0;
            T0:   state_d = T1;
            T1:   state_d = T1W;
            T1W:  if (MemReady) state_d = T2;
            T2:   state_d = T3;
            T3:   state_d = is_br ? T4 : IDLE;
            T4:   state_d = T5;
            T5:   state_d = T6;
            T6: begin
                state_d = IDLE;
                // Counter sticks at all-ones rather than wrapping.
                if (CON && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Enables decode straight from the state register so Clear blanks them at once.
    always_comb begin
        PCout     = 1'b0;
        MARin     = 1'b0;
        IncPC     = 1'b0;
        Zin       = 1'b0;
        Zlowout   = 1'b0;
        PCin      = 1'b0;
        Read      = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        Gra       = 1'b0;
        Rout      = 1'b0;
        CONin     = 1'b0;
        Yin       = 1'b0;
        Cout      = 1'b0;
        ADD       = 1'b0;
        Done      = 1'b0;
        NotBranch = 1'b0;
        Busy      = (state_q != IDLE);
        unique case (state_q)
            IDLE: ;
            T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
            end
            T1W: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                if (is_br) begin
                    Gra   = 1'b1;
                    Rout  = 1'b1;
                    CONin = 1'b1;
                end else begin
                    Done      = 1'b1;
                    NotBranch = 1'b1;
                end
            end
            T4: begin
                PCout = 1'b1;
                Yin   = 1'b1;
            end
            T5: begin
                Cout = 1'b1;
                ADD  = 1'b1;
                Zin  = 1'b1;
            end
            T6: begin
                Zlowout = 1'b1;
                PCin    = CON;
                Done    = 1'b1;
            end
            default: ;
        endcase
    end

    assign TakenCount = cnt_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: directed and random instructions against a step-list model,
// with small plant models of the IR register and the branch-condition flip-flop.
module tb_branch_sequencer;

    localparam logic [4:0] BR = 5'b10010;

    localparam logic [18:0] M_PCOUT  = 19'd1 << 18;
    localparam logic [18:0] M_MARIN  = 19'd1 << 17;
    localparam logic [18:0] M_INCPC  = 19'd1 << 16;
    localparam logic [18:0] M_ZIN    = 19'd1 << 15;
    localparam logic [18:0] M_ZLO    = 19'd1 << 14;
    localparam logic [18:0] M_PCIN   = 19'd1 << 13;
    localparam logic [18:0] M_READ   = 19'd1 << 12;
    localparam logic [18:0] M_MDRIN  = 19'd1 << 11;
    localparam logic [18:0] M_MDROUT = 19'd1 << 10;
    localparam logic [18:0] M_IRIN   = 19'd1 << 9;
    localparam logic [18:0] M_GRA    = 19'd1 << 8;
    localparam logic [18:0] M_ROUT   = 19'd1 << 7;
    localparam logic [18:0] M_CONIN  = 19'd1 << 6;
    localparam logic [18:0] M_YIN    = 19'd1 << 5;
    localparam logic [18:0] M_COUT   = 19'd1 << 4;
    localparam logic [18:0] M_ADD    = 19'd1 << 3;
    localparam logic [18:0] M_BUSY   = 19'd1 << 2;
    localparam logic [18:0] M_DONE   = 19'd1 << 1;
    localparam logic [18:0] M_NOTBR  = 19'd1;

    logic        Clock = 1'b0;
    logic        Clear = 1'b1;
    logic        Start = 1'b0;
    logic        MemReady = 1'b0;
    logic [31:0] ir_reg = 32'h0;
    logic        con_ff = 1'b0;
    logic [31:0] ir_mem = 32'h0;
    logic [31:0] ra_val = 32'h0;

    logic PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin;
    logic Gra, Rout, CONin, Yin, Cout, ADD, Busy, Done, NotBranch;
    logic [15:0] TakenCount;
    logic PCout2, MARin2, IncPC2, Zin2, Zlowout2, PCin2, Read2, MDRin2, MDRout2, IRin2;
    logic Gra2, Rout2, CONin2, Yin2, Cout2, ADD2, Busy2, Done2, NotBranch2;
    logic [1:0] TakenCount2;
    logic [18:0] obs, obs2;

    int tests = 0;
    int fails = 0;
    int model_taken = 0;

    always #5 Clock = ~Clock;

    branch_sequencer #(.BR_OPCODE(BR), .CNT_W(16)) dut (
        .Clock(Clock), .Clear(Clear), .Start(Start), .MemReady(MemReady), .IR(ir_reg), .CON(con_ff),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout), .PCin(PCin),
        .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Gra(Gra), .Rout(Rout),
        .CONin(CONin), .Yin(Yin), .Cout(Cout), .ADD(ADD), .Busy(Busy), .Done(Done),
        .NotBranch(NotBranch), .TakenCount(TakenCount)
    );

    branch_sequencer #(.BR_OPCODE(BR), .CNT_W(2)) dut_sat (
        .Clock(Clock), .Clear(Clear), .Start(Start), .MemReady(MemReady), .IR(ir_reg), .CON(con_ff),
        .PCout(PCout2), .MARin(MARin2), .IncPC(IncPC2), .Zin(Zin2), .Zlowout(Zlowout2), .PCin(PCin2),
        .Read(Read2), .MDRin(MDRin2), .MDRout(MDRout2), .IRin(IRin2), .Gra(Gra2), .Rout(Rout2),
        .CONin(CONin2), .Yin(Yin2), .Cout(Cout2), .ADD(ADD2), .Busy(Busy2), .Done(Done2),
        .NotBranch(NotBranch2), .TakenCount(TakenCount2)
    );

    assign obs  = {PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin,
                   Gra, Rout, CONin, Yin, Cout, ADD, Busy, Done, NotBranch};
    assign obs2 = {PCout2, MARin2, IncPC2, Zin2, Zlowout2, PCin2, Read2, MDRin2, MDRout2, IRin2,
                   Gra2, Rout2, CONin2, Yin2, Cout2, ADD2, Busy2, Done2, NotBranch2};

    // Branch condition on Ra selected by C2: zero, nonzero, positive-or-zero, negative.
    function automatic logic cond(input logic [31:0] ra, input logic [1:0] c2);
        case (c2)
            2'd0:    return ra == 32'd0;
            2'd1:    return ra != 32'd0;
            2'd2:    return !ra[31];
            default: return ra[31];
        endcase
    endfunction

    // Plant: IR register and condition flip-flop loaded by the sequencer's enables.
    always @(posedge Clock) begin
        if (IRin) ir_reg <= ir_mem;
        if (CONin) con_ff <= cond(ra_val, ir_reg[20:19]);
    end

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic check_counts(input string tag);
        check({tag, "_cnt16"}, {16'h0, TakenCount}, sat(model_taken, 65535));
        check({tag, "_cnt2"}, {30'h0, TakenCount2}, sat(model_taken, 3));
    endtask

    // Runs one instruction from IDLE; entered and left at posedge+1 with the DUT in IDLE.
    task automatic run_instr(input string tag, input logic [31:0] ir, input logic [31:0] ra,
                             input int waits, input bit noise);
        logic [18:0] exp_q[$];
        bit          mr_q[$];
        bit          br, taken;
        br    = (ir[31:27] == BR);
        taken = br && cond(ra, ir[20:19]);
        exp_q.push_back(M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_BUSY);  mr_q.push_back(1'($urandom));
        exp_q.push_back(M_ZLO | M_PCIN | M_READ | M_BUSY);              mr_q.push_back(1'($urandom));
        for (int w = 0; w <= waits; w++) begin
            exp_q.push_back(M_READ | M_MDRIN | M_BUSY);                 mr_q.push_back(w == waits);
        end
        exp_q.push_back(M_MDROUT | M_IRIN | M_BUSY);                    mr_q.push_back(1'($urandom));
        if (br) begin
            exp_q.push_back(M_GRA | M_ROUT | M_CONIN | M_BUSY);         mr_q.push_back(1'($urandom));
            exp_q.push_back(M_PCOUT | M_YIN | M_BUSY);                  mr_q.push_back(1'($urandom));
            exp_q.push_back(M_COUT | M_ADD | M_ZIN | M_BUSY);           mr_q.push_back(1'($urandom));
            exp_q.push_back(M_ZLO | (taken ? M_PCIN : 19'd0) | M_BUSY | M_DONE);
            mr_q.push_back(1'($urandom));
        end else begin
            exp_q.push_back(M_BUSY | M_DONE | M_NOTBR);                 mr_q.push_back(1'($urandom));
        end
        ir_mem   = ir;
        ra_val   = ra;
        Start    = 1'b1;
        MemReady = 1'($urandom);
        @(negedge Clock);
        check({tag, "_idle"}, {13'h0, obs}, 32'h0);
        check_counts({tag, "_pre"});
        @(posedge Clock); #1;
        foreach (exp_q[i]) begin
            Start    = noise ? 1'($urandom) : 1'b0;
            MemReady = mr_q[i];
            @(negedge Clock);
            check($sformatf("%s_step%0d", tag, i), {13'h0, obs}, {13'h0, exp_q[i]});
            check($sformatf("%s_sat_step%0d", tag, i), {13'h0, obs2}, {13'h0, exp_q[i]});
            check($sformatf("%s_cnt_hold%0d", tag, i), {30'h0, TakenCount2}, sat(model_taken, 3));
            @(posedge Clock); #1;
        end
        Start = 1'b0;
        if (taken) model_taken++;
        @(negedge Clock);
        check({tag, "_back_idle"}, {13'h0, obs}, 32'h0);
        check_counts({tag, "_post"});
        @(posedge Clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ir, ra;
        // Reset
        @(negedge Clock);
        check("reset_outputs", {13'h0, obs}, 32'h0);
        check_counts("reset");
        @(posedge Clock); #1;
        Clear = 1'b0;
        @(posedge Clock); #1;

        run_instr("taken_brzr", 32'h9000_0000, 32'h0, 0, 1'b0);
        run_instr("nottaken_brnz", 32'h9008_0000, 32'h0, 0, 1'b0);
        run_instr("memwait_brpl", 32'h9010_0000, 32'h0000_1234, 3, 1'b0);
        run_instr("nonbranch", 32'h1800_0000, 32'h0, 1, 1'b1);
        for (int k = 0; k < 4; k++)
            run_instr($sformatf("taken_brmi%0d", k), 32'h9018_0000, 32'h8000_0000 | k, k, 1'b1);
        check("saturate_cnt2", {30'h0, TakenCount2}, 32'd3);
        check("unsat_cnt16", {16'h0, TakenCount}, 32'd6);

        for (int n = 0; n < 40; n++) begin
            ir = $urandom;
            if ($urandom_range(9) < 7) ir[31:27] = BR;
            else if (ir[31:27] == BR) ir[31:27] = 5'b00011;
            case ($urandom_range(3))
                0:       ra = 32'h0;
                1:       ra = 32'h8000_0000 | $urandom;
                default: ra = $urandom;
            endcase
            run_instr($sformatf("rand%0d", n), ir, ra, $urandom_range(4), 1'b1);
        end

        // Clear asserted mid-T5 abandons the instruction immediately
        Start    = 1'b1;
        ir_mem   = 32'h9000_0000;
        ra_val   = 32'h0;
        MemReady = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (6) begin
            @(posedge Clock); #1;
        end
        @(negedge Clock);
        check("pre_clear_t5", {13'h0, obs}, {13'h0, M_COUT | M_ADD | M_ZIN | M_BUSY});
        #1 Clear = 1'b1;
        #1;
        check("clear_async_outputs", {13'h0, obs}, 32'h0);
        check("clear_async_cnt16", {16'h0, TakenCount}, 32'h0);
        check("clear_async_cnt2", {30'h0, TakenCount2}, 32'h0);
        model_taken = 0;
        @(posedge Clock); #1;
        Clear = 1'b0;
        @(negedge Clock);
        check("after_clear_idle", {13'h0, obs}, 32'h0);
        @(posedge Clock); #1;
        run_instr("post_clear_taken", 32'h9000_0000, 32'h0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Control-step sequencer for the conditional-branch (`br`) instruction path of the Mini SRC datapath. It steps the shared bus through fetch (T0–T2) and branch execution (T3–T6), waits on memory, and drives CONin so the condition flip-flop samples Ra. It applies PCin in T6 only when the flip-flop's registered CON output is 1. It sits between the top-level control unit (Start/Done handshake) and the datapath register enables, and keeps a saturating count of taken branches.

## Interface
- BR_OPCODE, 5'b10010, opcode value in IR[31:27] that identifies `br`
- CNT_W, 16, width of taken-branch counter
- Clock  in  1  system clock, rising edge
- Clear  in  1  reset, asynchronous, active-high
- Start  in  1  request to run one instruction; sampled only in IDLE
- MemReady  in  1  memory read data valid on Mdatain this cycle
- IR  in  32  IR register output (valid from T3 onward)
- CON  in  1  registered branch-condition output of the condition flip-flop
- PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Gra, Rout, CONin, Yin, Cout, ADD  out  1 each  datapath enables
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle pulse at end of instruction
- NotBranch  out  1  qualifies Done: fetched opcode ≠ BR_OPCODE
- TakenCount  out  CNT_W  number of taken branches, saturating

## Operation
- States: IDLE, T0, T1, T1W, T2, T3, T4, T5, T6. All outputs are decoded from the state. T3 and T6 also depend on IR and CON.
- IDLE: all enables 0. Start=1 → T0. Otherwise stay.
- T0: PCout, MARin, IncPC, Zin → T1.
- T1: Zlowout, PCin, Read → T1W.
- T1W: Read, MDRin held. Stay while MemReady=0; MemReady=1 → T2 (MDRin captured that edge). No timeout.
- T2: MDRout, IRin → T3.
- T3: if IR[31:27]==BR_OPCODE: Gra, Rout, CONin → T4. Else: no enables; Done=1, NotBranch=1 → IDLE.
- T4: PCout, Yin → T5. CON now reflects the condition on Ra, with C2 taken from IR[20:19].
- T5: Cout, ADD, Zin → T6.
- T6: Zlowout always. PCin = CON. Done=1, NotBranch=0 → IDLE. If CON=1 and TakenCount≠all-ones, TakenCount increments at the edge that leaves T6.
- No two bus drivers (PCout, Zlowout, MDRout, Rout, Cout) are ever high in the same state.
- Start during non-IDLE states is ignored. It is not queued.
- Clear at any point asynchronously forces IDLE and TakenCount=0. This includes mid-T1W and mid-T6. All enables, Busy, Done and NotBranch go 0 immediately. A partially executed instruction is abandoned with no Done.

## Timing
- Reset values: state IDLE, every output 0, TakenCount 0.
- Start sampled high at edge k → T0 during cycle k+1.
- Branch with MemReady high in the first T1W cycle: 8 cycles T0..T6, Done in the 8th.
- Each extra cycle of MemReady=0 adds one T1W cycle.
- Non-branch opcode: 5 cycles (T0–T3), Done+NotBranch in T3.
- Start high in the Done cycle is ignored, because the state is not IDLE. The earliest new T0 is 2 cycles after Done if Start is held.
- CON is sampled combinationally in T6. It must be the value registered at the end of T3.

## Test plan
- Reset: assert Clear mid-T5 → same cycle all outputs 0, Busy 0. After release, state is IDLE and TakenCount=0.
- Taken brzr: IR=0x9000_0000 (opcode 10010, C2=00), Ra=0 (CON=1 in T4), MemReady=1 → PCin high in T1 and T6. Done in cycle 8. TakenCount 0→1.
- Not-taken brnz: IR with C2=01, Ra=0 (CON=0) → T6 has Zlowout=1, PCin=0, Done=1. TakenCount unchanged.
- Memory wait: MemReady low for 3 cycles in T1W → Read and MDRin held 4 cycles. Done in cycle 11. PCin never high in T1W.
- Non-branch: IR[31:27]=00011 → Done=1, NotBranch=1 in T3. CONin never asserted. Back to IDLE. Start pulses while Busy produce no extra instruction.
- Saturation: CNT_W=2, run 5 taken branches → TakenCount ends at 3.
